// File: rtl/rainbow_pwm_fader.sv
// RGB hue-wheel crossfader: walks R>Y>G>C>B>M and time-slices the past and
// future base colours within each PWM frame according to a blend weight.
module rainbow_pwm_fader #(
    parameter int TICKS_PER_SLOT  = 12000,
    parameter int PWM_STEPS       = 32,
    parameter int FRAMES_PER_STEP = 4,
    parameter int ACTIVE_LOW      = 1,
    localparam int W              = $clog2(PWM_STEPS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         hold,
    input  logic         dir,
    output logic [2:0]   led,
    output logic [2:0]   hue_idx,
    output logic [W-1:0] weight,
    output logic         step_stb,
    output logic         cycle_stb
);

    localparam int TW = (TICKS_PER_SLOT > 1) ? $clog2(TICKS_PER_SLOT) : 1;
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SLOT - 1);
    localparam logic [W-1:0]  SLOT_LAST  = W'(PWM_STEPS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);
    localparam logic [W:0]    STEPS_EXT  = (W+1)'(PWM_STEPS);
    localparam logic [2:0]    LED_OFF    = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

    // Active-high base colour for a wheel index.
    function automatic logic [2:0] base_colour(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = 3'b100;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b010;
            3'd3:    c = 3'b011;
            3'd4:    c = 3'b001;
            3'd5:    c = 3'b101;
            default: c = 3'b100;
        endcase
        return c;
    endfunction

    // Neighbouring wheel index, modulo 6.
    function automatic logic [2:0] hue_step(input logic [2:0] idx, input logic rev);
        logic [2:0] n;
        if (rev) begin
            if (idx == 3'd0) n = 3'd5;
            else             n = idx - 3'd1;
        end else begin
            if (idx >= 3'd5) n = 3'd0;
            else             n = idx + 3'd1;
        end
        return n;
    endfunction

    logic [TW-1:0] r_tick;
    logic [W-1:0]  r_slot;
    logic [FW-1:0] r_frame;
    logic [W-1:0]  r_weight;
    logic [2:0]    r_hue;
    logic          r_dir_q;
    logic [2:0]    r_led;
    logic          r_step_stb;
    logic          r_cycle_stb;

    logic [TW-1:0] w_tick_nxt;
    logic [W-1:0]  w_slot_nxt;
    logic [FW-1:0] w_frame_nxt;
    logic [W-1:0]  w_weight_nxt;
    logic [2:0]    w_hue_nxt;
    logic          w_dir_nxt;
    logic [2:0]    w_led_nxt;
    logic          w_step_nxt;
    logic          w_cycle_nxt;
    logic [2:0]    w_future_idx;
    logic          w_show_future;

    // Counter chain, blend/hue advance and colour selection for the next edge.
    always_comb begin
        w_tick_nxt    = r_tick;
        w_slot_nxt    = r_slot;
        w_frame_nxt   = r_frame;
        w_weight_nxt  = r_weight;
        w_hue_nxt     = r_hue;
        w_dir_nxt     = r_dir_q;
        w_led_nxt     = LED_OFF;
        w_step_nxt    = 1'b0;
        w_cycle_nxt   = 1'b0;
        w_future_idx  = hue_step(r_hue, r_dir_q);
        // The last weight slots of each frame show the future colour.
        w_show_future = ({1'b0, r_slot} >= (STEPS_EXT - {1'b0, r_weight}));
        if (en) begin
            w_led_nxt = (w_show_future ? base_colour(w_future_idx) : base_colour(r_hue)) ^ LED_OFF;
            if (r_tick == TICK_LAST) begin
                w_tick_nxt = {TW{1'b0}};
                if (r_slot == SLOT_LAST) begin
                    w_slot_nxt = {W{1'b0}};
                    if (r_frame == FRAME_LAST) begin
                        w_frame_nxt = {FW{1'b0}};
                        if (!hold) begin
                            w_step_nxt = 1'b1;
                            if (r_weight == SLOT_LAST) begin
                                // Future colour becomes the new past colour.
                                w_weight_nxt = {W{1'b0}};
                                w_hue_nxt    = w_future_idx;
                                w_dir_nxt    = dir;
                                w_cycle_nxt  = r_dir_q ? (r_hue == 3'd0) : (r_hue == 3'd5);
                            end else begin
                                w_weight_nxt = r_weight + W'(1);
                            end
                        end else begin
                            w_step_nxt = 1'b0;
                        end
                    end else begin
                        w_frame_nxt = r_frame + FW'(1);
                    end
                end else begin
                    w_slot_nxt = r_slot + W'(1);
                end
            end else begin
                w_tick_nxt = r_tick + TW'(1);
            end
        end else begin
            w_led_nxt = LED_OFF;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick      <= {TW{1'b0}};
            r_slot      <= {W{1'b0}};
            r_frame     <= {FW{1'b0}};
            r_weight    <= {W{1'b0}};
            r_hue       <= 3'd0;
            r_dir_q     <= 1'b0;
            r_led       <= LED_OFF;
            r_step_stb  <= 1'b0;
            r_cycle_stb <= 1'b0;
        end else begin
            r_tick      <= w_tick_nxt;
            r_slot      <= w_slot_nxt;
            r_frame     <= w_frame_nxt;
            r_weight    <= w_weight_nxt;
            r_hue       <= w_hue_nxt;
            r_dir_q     <= w_dir_nxt;
            r_led       <= w_led_nxt;
            r_step_stb  <= w_step_nxt;
            r_cycle_stb <= w_cycle_nxt;
        end
    end

    assign led       = r_led;
    assign hue_idx   = r_hue;
    assign weight    = r_weight;
    assign step_stb  = r_step_stb;
    assign cycle_stb = r_cycle_stb;

endmodule

// File: tb/tb_rainbow_pwm_fader.sv
// Bench for rainbow_pwm_fader: directed vector table, corner sequences and
// randomized run against a frame-position reference model.
module tb_rainbow_pwm_fader;

    localparam int T = 2;
    localparam int S = 4;
    localparam int F = 2;

    logic       clk = 1'b0;
    logic       rst, en, hold, dir;
    logic [2:0] led, hue_idx;
    logic [1:0] weight;
    logic       step_stb, cycle_stb;

    always #5 clk = ~clk;

    rainbow_pwm_fader #(
        .TICKS_PER_SLOT(T), .PWM_STEPS(S), .FRAMES_PER_STEP(F), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .dir(dir),
        .led(led), .hue_idx(hue_idx), .weight(weight),
        .step_stb(step_stb), .cycle_stb(cycle_stb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position inside the frame in clk cycles, plus blend state.
    int   m_phase, m_frame, m_weight, m_hue, m_dq;
    logic [2:0] m_led;
    bit   m_step, m_cyc;
    int   base_tab [6] = '{4, 6, 2, 3, 1, 5};

    typedef struct {
        bit rst, en, hold, dir;
        int n;
        int led, hue, wgt;
        bit step, cyc;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int fut;
        if (rst) begin
            m_phase = 0; m_frame = 0; m_weight = 0; m_hue = 0; m_dq = 0;
            m_led = 3'b111; m_step = 0; m_cyc = 0;
        end else if (!en) begin
            m_led = 3'b111; m_step = 0; m_cyc = 0;
        end else begin
            fut    = m_dq ? (m_hue + 5) % 6 : (m_hue + 1) % 6;
            m_led  = 3'(7 - (((m_phase / T) < (S - m_weight)) ? base_tab[m_hue] : base_tab[fut]));
            m_step = 0;
            m_cyc  = 0;
            m_phase++;
            if (m_phase == T * S) begin
                m_phase = 0;
                m_frame++;
                if (m_frame == F) begin
                    m_frame = 0;
                    if (!hold) begin
                        m_step = 1;
                        m_weight++;
                        if (m_weight == S) begin
                            m_weight = 0;
                            m_cyc    = (m_dq == 0 && m_hue == 5) || (m_dq == 1 && m_hue == 0);
                            m_hue    = fut;
                            m_dq     = dir;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_led",    int'(led),       int'(m_led));
        chk("model_hue",    int'(hue_idx),   m_hue);
        chk("model_weight", int'(weight),    m_weight);
        chk("model_step",   int'(step_stb),  int'(m_step));
        chk("model_cycle",  int'(cycle_stb), int'(m_cyc));
    endtask

    task automatic do_reset(input logic d);
        rst = 1'b1; en = 1'b1; hold = 1'b0; dir = d;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    initial begin
        int steps, cycles, waited;
        logic [1:0] w0;
        rst = 1'b1; en = 1'b1; hold = 1'b0; dir = 1'b0;
        m_phase = 0; m_frame = 0; m_weight = 0; m_hue = 0; m_dq = 0;
        m_led = 3'b111; m_step = 0; m_cyc = 0;

        // {rst,en,hold,dir, cycles, led,hue,weight,step,cycle}
        tbl[0]  = '{1, 1, 0, 0,  3, 7, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0,  1, 3, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0,  7, 3, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 0,  8, 3, 0, 1, 1, 0};
        tbl[4]  = '{0, 1, 0, 0,  6, 3, 0, 1, 0, 0};
        tbl[5]  = '{0, 1, 0, 0,  1, 1, 0, 1, 0, 0};
        tbl[6]  = '{0, 1, 0, 0,  2, 3, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0,  1, 7, 0, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 19, 7, 0, 1, 0, 0};
        tbl[9]  = '{0, 1, 0, 0,  1, 3, 0, 1, 0, 0};
        tbl[10] = '{0, 1, 0, 0,  4, 3, 0, 1, 0, 0};
        tbl[11] = '{0, 1, 0, 0,  1, 1, 0, 1, 0, 0};
        tbl[12] = '{0, 1, 0, 0,  1, 1, 0, 2, 1, 0};
        tbl[13] = '{0, 1, 0, 0,  1, 3, 0, 2, 0, 0};

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; hold = tbl[i].hold; dir = tbl[i].dir;
            repeat (tbl[i].n) cyc();
            chk($sformatf("vec%0d_led", i),    int'(led),       tbl[i].led);
            chk($sformatf("vec%0d_hue", i),    int'(hue_idx),   tbl[i].hue);
            chk($sformatf("vec%0d_weight", i), int'(weight),    tbl[i].wgt);
            chk($sformatf("vec%0d_step", i),   int'(step_stb),  int'(tbl[i].step));
            chk($sformatf("vec%0d_cycle", i),  int'(cycle_stb), int'(tbl[i].cyc));
        end

        // Full forward wheel: six 64-cycle segments.
        do_reset(1'b0);
        steps = 0; cycles = 0;
        for (int e = 1; e <= 384; e++) begin
            cyc();
            steps  += int'(step_stb);
            cycles += int'(cycle_stb);
            if (e == 63)     chk("wheel_hue_e63", int'(hue_idx), 0);
            if (e % 64 == 0) chk($sformatf("wheel_hue_e%0d", e), int'(hue_idx), (e / 64) % 6);
            if (e == 384)    chk("wheel_cycle_stb_at_wrap", int'(cycle_stb), 1);
        end
        chk("wheel_step_count", steps, 24);
        chk("wheel_cycle_count", cycles, 1);

        // Reverse: dir_q only picks up dir at the first hue advance.
        do_reset(1'b1);
        for (int e = 1; e <= 256; e++) begin
            cyc();
            if (e == 64)  chk("rev_hue_e64", int'(hue_idx), 1);
            if (e == 128) chk("rev_hue_e128", int'(hue_idx), 0);
            if (e == 151) chk("rev_led_toward_m", int'(led), 3'b010);
            if (e == 192) chk("rev_hue_e192", int'(hue_idx), 5);
            if (e == 192) chk("rev_cycle_stb", int'(cycle_stb), 1);
            if (e == 256) chk("rev_hue_e256", int'(hue_idx), 4);
        end

        // Hold for 40 cycles: weight frozen, no strobes.
        dir = 1'b0;
        repeat (5) cyc();
        hold = 1'b1;
        w0 = 2'(m_weight);
        steps = 0;
        repeat (40) begin
            cyc();
            steps += int'(step_stb) + int'(cycle_stb);
        end
        chk("hold_weight", int'(weight), int'(w0));
        chk("hold_no_strobes", steps, 0);
        hold = 1'b0;

        // Reset mid-run at weight=2, hue=3.
        do_reset(1'b0);
        waited = 0;
        while (!(m_hue == 3 && m_weight == 2) && waited < 2000) begin
            cyc();
            waited++;
        end
        chk("midrun_reach_target", int'(waited < 2000), 1);
        rst = 1'b1;
        cyc();
        chk("midrun_rst_led", int'(led), 7);
        chk("midrun_rst_hue", int'(hue_idx), 0);
        chk("midrun_rst_weight", int'(weight), 0);
        chk("midrun_rst_step", int'(step_stb), 0);
        rst = 1'b0;
        cyc();
        chk("midrun_first_red", int'(led), 3);

        // Randomized run against the model.
        for (int k = 0; k < 3000; k++) begin
            rst  = ($urandom_range(0, 299) == 0);
            en   = ($urandom_range(0, 9) != 0);
            hold = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) dir = ~dir;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
